// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage.
// Decode imports the same NOP/HALT encodings, so keep them in sync here.
package fetch_pkg;

    localparam logic [15:0] NOP_INST = 16'h0000;
    localparam logic [3:0]  HALT_OP  = 4'hF;
    localparam int          CNT_W    = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_halt(input logic [15:0] inst);
        return inst[15:12] == HALT_OP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of signals between the fetch stage, instruction memory and decode.
// The master modport is the fetch stage itself.
interface fetch_stage_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
);
    logic              stopPipe;
    logic              selPC;
    logic [PC_W-1:0]   BranchPC;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] instD;
    logic [PC_W-1:0]   pcD;
    logic              validD;
    logic              halted;
    logic [15:0]       fetchCount;

    modport master (
        input  stopPipe, selPC, BranchPC, imem_data,
        output imem_addr, instD, pcD, validD, halted, fetchCount
    );

    modport slave (
        output stopPipe, selPC, BranchPC, imem_data,
        input  imem_addr, instD, pcD, validD, halted, fetchCount
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC and valid bit.
// flush beats stop, so a redirect always inserts a bubble even while stalled.
module IF_ID_Reg
    import fetch_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stop_i,
    input  logic              flush_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              valid_o
);

    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   pc_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (!stop_i) begin
            inst_q  <= inst_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, RUN/HALT FSM,
// saturating fetch counter, and the IF/ID register feeding decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop, flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect outranks stall; in HALT only reset gets us out.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        stop    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.selPC) begin
                    pc_d  = bus.BranchPC;
                    flush = 1'b1;
                end else if (bus.stopPipe) begin
                    stop = 1'b1;
                end else begin
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                    if (is_halt(bus.imem_data))
                        state_d = HALT;
                    else
                        pc_d = pc_q + PC_W'(1);
                end
            end
            HALT: flush = 1'b1;
            default: flush = 1'b1;
        endcase
    end

    IF_ID_Reg #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst),
        .stop_i  (stop),
        .flush_i (flush),
        .inst_i  (bus.imem_data),
        .pc_i    (pc_q),
        .inst_o  (bus.instD),
        .pc_o    (bus.pcD),
        .valid_o (bus.validD)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.halted     = (state_q == HALT);
    assign bus.fetchCount = cnt_q;

endmodule
